ram_ref_arb: RTL



---
 rtl/ram_pkg.sv | 32 +++
 rtl/ram_tmr.sv | 25 ++
 rtl/ram_ref_arb.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared constants and payload types for the DRAM bus sequencer/refresh arbiter.
package ram_pkg;

    localparam int unsigned CNT_W = 3;

    // State encoding
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ROW  = 3'd1;
    localparam logic [2:0] COL  = 3'd2;
    localparam logic [2:0] PRE  = 3'd3;
    localparam logic [2:0] REFC = 3'd4;
    localparam logic [2:0] REFR = 3'd5;

    // Default DRAM timing, in FSB clocks
    localparam int unsigned TRCD_DEF = 1;
    localparam int unsigned TCAS_DEF = 2;
    localparam int unsigned TRP_DEF  = 2;
    localparam int unsigned TREF_DEF = 4;

    // Registered pin values for one bus cycle
    typedef struct packed {
        logic ras_n;
        logic cas_n;
        logic row_sel;
        logic ready;
        logic ref_busy;
    } bus_out_t;

    localparam bus_out_t BUS_IDLE = '{ras_n: 1'b1, cas_n: 1'b1, row_sel: 1'b1,
                                      ready: 1'b0, ref_busy: 1'b0};

endpackage

// File: rtl/ram_tmr.sv
// Loadable down-counter timing every sequencer state; stops at zero.
module ram_tmr
    import ram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tc_c = (cnt == '0);

endmodule

// File: rtl/ram_ref_arb.sv
// DRAM bus sequencer sharing the bus between CPU accesses and CBR refresh.
// Optional sticky missed-refresh flag enabled with `define RAM_REFMISS_EN.
module ram_ref_arb
    import ram_pkg::*;
#(
    parameter int unsigned TRCD = TRCD_DEF,
    parameter int unsigned TCAS = TCAS_DEF,
    parameter int unsigned TRP  = TRP_DEF,
    parameter int unsigned TREF = TREF_DEF
) (
    input  logic CLK,
    input  logic RES,
    input  logic RefReq,
    input  logic RefUrg,
    input  logic RAMReq,
    output logic RAMReady,
    output logic nRAS,
    output logic nCAS,
    output logic RowSel,
    output logic RefBusy,
    output logic RefMiss
);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_cnt;
    logic             tmr_tc;
    logic             ref_done;
    logic             ref_need;
    logic             refr_exit;
    bus_out_t         out_nxt;

    ram_tmr u_tmr (
        .clk      (CLK),
        .rst      (RES),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .tc_c     (tmr_tc)
    );

    assign ref_need  = RefReq && !ref_done;
    assign refr_exit = (state == REFR) && tmr_tc;

    // Next state, timer reload on state entry, and next-cycle pin values
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        out_nxt   = BUS_IDLE;

        case (state)
            IDLE: begin
                if (ref_need && (RefUrg || !RAMReq)) begin
                    state_nxt = REFC;
                end else if (RAMReq) begin
                    state_nxt = ROW;
                end
            end
            ROW:     if (tmr_tc) state_nxt = COL;
            COL:     if (tmr_tc) state_nxt = PRE;
            REFC:    if (tmr_tc) state_nxt = REFR;
            REFR:    if (tmr_tc) state_nxt = PRE;
            PRE:     if (tmr_tc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state) begin
            tmr_load = 1'b1;
            case (state_nxt)
                ROW:     tmr_val = CNT_W'(TRCD - 1);
                COL:     tmr_val = CNT_W'(TCAS - 1);
                REFR:    tmr_val = CNT_W'(TREF - 1);
                PRE:     tmr_val = CNT_W'(TRP - 1);
                default: tmr_val = '0;
            endcase
        end

        case (state_nxt)
            ROW: begin
                out_nxt.ras_n = 1'b0;
            end
            COL: begin
                out_nxt.ras_n   = 1'b0;
                out_nxt.cas_n   = 1'b0;
                out_nxt.row_sel = 1'b0;
                // Ready lands on the cycle whose reloaded/decremented count is zero
                out_nxt.ready   = (state != COL) ? (TCAS == 1) : (tmr_cnt == CNT_W'(1));
            end
            REFC: begin
                out_nxt.cas_n    = 1'b0;
                out_nxt.ref_busy = 1'b1;
            end
            REFR: begin
                out_nxt.ras_n    = 1'b0;
                out_nxt.cas_n    = 1'b0;
                out_nxt.ref_busy = 1'b1;
            end
            default: out_nxt = BUS_IDLE;
        endcase
    end

    // State, registered pins and per-window refresh bookkeeping
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state    <= IDLE;
            nRAS     <= 1'b1;
            nCAS     <= 1'b1;
            RowSel   <= 1'b1;
            RAMReady <= 1'b0;
            RefBusy  <= 1'b0;
            ref_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            nRAS     <= out_nxt.ras_n;
            nCAS     <= out_nxt.cas_n;
            RowSel   <= out_nxt.row_sel;
            RAMReady <= out_nxt.ready;
            RefBusy  <= out_nxt.ref_busy;
            // A closed window clears the flag even on the cycle a refresh completes
            ref_done <= RefReq && (ref_done || refr_exit);
        end
    end

`ifdef RAM_REFMISS_EN
    logic ref_req_q;
    logic ref_miss;

    // Window closed before any refresh completed in it
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ref_req_q <= 1'b0;
            ref_miss  <= 1'b0;
        end else begin
            ref_req_q <= RefReq;
            if (ref_req_q && !RefReq && !ref_done) begin
                ref_miss <= 1'b1;
            end
        end
    end

    assign RefMiss = ref_miss;
`else
    assign RefMiss = 1'b0;
`endif

endmodule
